// File: rtl/cae_row_feeder.sv
// Row sequencer between the feature-map/weight buffers and the three-row PE array.
// Loads a 3-row weight set and a 3-row data window, then slides the window (conv) or the weights (FC).
`ifndef INPUT_SIZE
`define INPUT_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BIAS_WIDTH
`define BIAS_WIDTH 16
`endif
`ifndef FC_WCOL_WIDTH
`define FC_WCOL_WIDTH 4
`endif

module cae_row_feeder #(
    parameter int unsigned INPUT_SIZE    = `INPUT_SIZE,
    parameter int unsigned DATA_WIDTH    = `DATA_WIDTH,
    parameter int unsigned BIAS_WIDTH    = `BIAS_WIDTH,
    parameter int unsigned FC_WCOL_WIDTH = `FC_WCOL_WIDTH,
    parameter int unsigned ADDR_WIDTH    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             layer_cfg,
    input  logic [ADDR_WIDTH-1:0]            num_rows,
    input  logic [BIAS_WIDTH-1:0]            bias_cfg,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             fm_rd_en,
    output logic [ADDR_WIDTH-1:0]            fm_rd_addr,
    input  logic [INPUT_SIZE*DATA_WIDTH-1:0] fm_rd_data,
    output logic                             wt_rd_en,
    output logic [ADDR_WIDTH-1:0]            wt_rd_addr,
    input  logic [INPUT_SIZE*DATA_WIDTH-1:0] wt_rd_data,
    output logic                             enable,
    output logic                             layer,
    output logic [FC_WCOL_WIDTH-1:0]         fc_wcol,
    output logic [BIAS_WIDTH-1:0]            bias,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0] data_row1,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0] data_row2,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0] data_row3,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0] weight_row1,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0] weight_row2,
    output logic [INPUT_SIZE*DATA_WIDTH-1:0] weight_row3,
    input  logic                             conv_comp,
    input  logic                             fc_line_done,
    input  logic                             fc_done
);

    localparam int unsigned RowW = INPUT_SIZE * DATA_WIDTH;

    typedef enum logic [2:0] {
        StIdle, StLoadW, StLoadD, StDrain, StRun, StShift, StNextW, StFinish
    } state_e;

    state_e                   state_q;
    logic [1:0]               cnt_q;
    logic [ADDR_WIDTH-1:0]    r_q, c_q, h_q;
    logic                     busy_q, done_q, err_q, enable_q, layer_q;
    logic                     fm_rd_en_q, wt_rd_en_q;
    logic [ADDR_WIDTH-1:0]    fm_rd_addr_q, wt_rd_addr_q;
    logic [FC_WCOL_WIDTH-1:0] fc_wcol_q;
    logic [BIAS_WIDTH-1:0]    bias_q;
    logic [RowW-1:0]          data_q [3];
    logic [RowW-1:0]          wt_q [3];
    // Read strobes delayed by one cycle tell which row the returning buffer data belongs to.
    logic                     fm_cap_q, wt_cap_q;
    logic [1:0]               fm_cap_idx_q, wt_cap_idx_q;
    logic [ADDR_WIDTH-1:0]    c_inc, c_inc_base;

    assign c_inc      = c_q + ADDR_WIDTH'(1);
    assign c_inc_base = (c_inc << 1) + c_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            h_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            enable_q     <= 1'b0;
            layer_q      <= 1'b0;
            fm_rd_en_q   <= 1'b0;
            wt_rd_en_q   <= 1'b0;
            fm_rd_addr_q <= '0;
            wt_rd_addr_q <= '0;
            fc_wcol_q    <= '0;
            bias_q       <= '0;
            fm_cap_q     <= 1'b0;
            wt_cap_q     <= 1'b0;
            fm_cap_idx_q <= '0;
            wt_cap_idx_q <= '0;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
                wt_q[i]   <= '0;
            end
        end else begin
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wt_cap_q     <= wt_rd_en_q;
            wt_cap_idx_q <= cnt_q;
            fm_cap_q     <= fm_rd_en_q;
            fm_cap_idx_q <= (state_q == StShift) ? 2'd2 : cnt_q;
            if (wt_cap_q) wt_q[wt_cap_idx_q] <= wt_rd_data;
            if (fm_cap_q) data_q[fm_cap_idx_q] <= fm_rd_data;

            unique case (state_q)
                StIdle, StFinish: begin
                    state_q <= StIdle;
                    if (start) begin
                        layer_q      <= layer_cfg;
                        h_q          <= num_rows;
                        bias_q       <= bias_cfg;
                        r_q          <= '0;
                        c_q          <= '0;
                        cnt_q        <= '0;
                        fc_wcol_q    <= '0;
                        fm_rd_addr_q <= '0;
                        wt_rd_addr_q <= '0;
                        if ((!layer_cfg && num_rows < ADDR_WIDTH'(3)) ||
                            (layer_cfg && num_rows == '0)) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                            err_q   <= !layer_cfg;
                        end else begin
                            state_q    <= StLoadW;
                            busy_q     <= 1'b1;
                            wt_rd_en_q <= 1'b1;
                        end
                    end
                end
                StLoadW, StNextW: begin
                    if (cnt_q == 2'd2) begin
                        cnt_q      <= '0;
                        wt_rd_en_q <= 1'b0;
                        if (state_q == StLoadW) begin
                            state_q    <= StLoadD;
                            fm_rd_en_q <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else begin
                        cnt_q        <= cnt_q + 2'd1;
                        wt_rd_addr_q <= wt_rd_addr_q + ADDR_WIDTH'(1);
                    end
                end
                StLoadD: begin
                    if (cnt_q == 2'd2) begin
                        cnt_q      <= '0;
                        fm_rd_en_q <= 1'b0;
                        state_q    <= StDrain;
                    end else begin
                        cnt_q        <= cnt_q + 2'd1;
                        fm_rd_addr_q <= fm_rd_addr_q + ADDR_WIDTH'(1);
                    end
                end
                StDrain: begin
                    state_q  <= StRun;
                    enable_q <= 1'b1;
                end
                StRun: begin
                    if (!layer_q && conv_comp) begin
                        enable_q <= 1'b0;
                        if (r_q + ADDR_WIDTH'(3) == h_q) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q      <= StShift;
                            data_q[0]    <= data_q[1];
                            data_q[1]    <= data_q[2];
                            fm_rd_en_q   <= 1'b1;
                            fm_rd_addr_q <= r_q + ADDR_WIDTH'(3);
                            r_q          <= r_q + ADDR_WIDTH'(1);
                        end
                    end else if (layer_q && fc_line_done) begin
                        enable_q <= 1'b0;
                        c_q      <= c_inc;
                        if (fc_done || c_inc == h_q) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q      <= StNextW;
                            cnt_q        <= '0;
                            wt_rd_en_q   <= 1'b1;
                            wt_rd_addr_q <= c_inc_base;
                            fc_wcol_q    <= FC_WCOL_WIDTH'(c_inc);
                        end
                    end
                end
                StShift: begin
                    fm_rd_en_q <= 1'b0;
                    state_q    <= StDrain;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign fm_rd_en    = fm_rd_en_q;
    assign fm_rd_addr  = fm_rd_addr_q;
    assign wt_rd_en    = wt_rd_en_q;
    assign wt_rd_addr  = wt_rd_addr_q;
    assign enable      = enable_q;
    assign layer       = layer_q;
    assign fc_wcol     = fc_wcol_q;
    assign bias        = bias_q;
    assign data_row1   = data_q[0];
    assign data_row2   = data_q[1];
    assign data_row3   = data_q[2];
    assign weight_row1 = wt_q[0];
    assign weight_row2 = wt_q[1];
    assign weight_row3 = wt_q[2];

endmodule

// File: tb/tb_cae_row_feeder.sv
// Directed bench for cae_row_feeder: buffer models, conv/FC jobs, degenerate configs, mid-job reset.
module tb_cae_row_feeder;

    localparam int IS = 4;
    localparam int DW = 8;
    localparam int BW = 16;
    localparam int FW = 4;
    localparam int AW = 8;
    localparam int RW = IS * DW;

    logic          clk = 1'b0;
    logic          rst, start, layer_cfg;
    logic [AW-1:0] num_rows;
    logic [BW-1:0] bias_cfg;
    logic          busy, done, err;
    logic          fm_rd_en, wt_rd_en;
    logic [AW-1:0] fm_rd_addr, wt_rd_addr;
    logic [RW-1:0] fm_rd_data, wt_rd_data;
    logic          enable, layer;
    logic [FW-1:0] fc_wcol;
    logic [BW-1:0] bias;
    logic [RW-1:0] data_row1, data_row2, data_row3;
    logic [RW-1:0] weight_row1, weight_row2, weight_row3;
    logic          conv_comp, fc_line_done, fc_done;

    logic [RW-1:0] fm_mem [256];
    logic [RW-1:0] wt_mem [256];
    logic [AW-1:0] fm_q [$];
    logic [AW-1:0] wt_q [$];
    int            n_tests = 0;
    int            n_fail  = 0;

    cae_row_feeder #(
        .INPUT_SIZE(IS), .DATA_WIDTH(DW), .BIAS_WIDTH(BW), .FC_WCOL_WIDTH(FW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .layer_cfg(layer_cfg), .num_rows(num_rows),
        .bias_cfg(bias_cfg), .busy(busy), .done(done), .err(err),
        .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .enable(enable), .layer(layer), .fc_wcol(fc_wcol), .bias(bias),
        .data_row1(data_row1), .data_row2(data_row2), .data_row3(data_row3),
        .weight_row1(weight_row1), .weight_row2(weight_row2), .weight_row3(weight_row3),
        .conv_comp(conv_comp), .fc_line_done(fc_line_done), .fc_done(fc_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fm_rd_en) fm_rd_data <= fm_mem[fm_rd_addr];
        if (wt_rd_en) wt_rd_data <= wt_mem[wt_rd_addr];
    end

    always @(negedge clk) begin
        if (fm_rd_en) fm_q.push_back(fm_rd_addr);
        if (wt_rd_en) wt_q.push_back(wt_rd_addr);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [RW-1:0] row_val(input int v);
        return {IS{v[7:0]}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic conv_job(input bit noise);
        fm_q.delete();
        layer_cfg = 1'b0;
        num_rows  = 8'd5;
        bias_cfg  = 16'h1234;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("conv_busy_c1", 64'(busy), 64'd1);
        chk("conv_wt_rd_c1", 64'(wt_rd_en), 64'd1);
        repeat (6) tick();
        chk("conv_en_c7", 64'(enable), 64'd0);
        tick();
        chk("conv_w1", 64'(weight_row1), 64'(wt_mem[0]));
        chk("conv_w3", 64'(weight_row3), 64'(wt_mem[2]));
        chk("conv_bias", 64'(bias), 64'h1234);
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("win%0d_en", w), 64'(enable), 64'd1);
            chk($sformatf("win%0d_r1", w), 64'(data_row1), 64'(row_val(w + 1)));
            chk($sformatf("win%0d_r2", w), 64'(data_row2), 64'(row_val(w + 2)));
            chk($sformatf("win%0d_r3", w), 64'(data_row3), 64'(row_val(w + 3)));
            if (noise && w == 0) begin
                layer_cfg = 1'b1;
                num_rows  = 8'd0;
                start     = 1'b1;
            end
            tick();
            start     = 1'b0;
            layer_cfg = 1'b0;
            num_rows  = 8'd5;
            chk($sformatf("win%0d_hold_en", w), 64'(enable), 64'd1);
            chk($sformatf("win%0d_layer", w), 64'(layer), 64'd0);
            conv_comp = 1'b1;
            tick();
            conv_comp = 1'b0;
            if (w == 2) begin
                chk("conv_done", 64'(done), 64'd1);
                chk("conv_done_en", 64'(enable), 64'd0);
                chk("conv_done_busy", 64'(busy), 64'd0);
                chk("conv_err", 64'(err), 64'd0);
                tick();
                chk("conv_done_pulse", 64'(done), 64'd0);
            end else begin
                chk($sformatf("shift%0d_en", w), 64'(enable), 64'd0);
                chk($sformatf("shift%0d_rd", w), 64'(fm_rd_en), 64'd1);
                chk($sformatf("shift%0d_addr", w), 64'(fm_rd_addr), 64'(w + 3));
                if (noise) conv_comp = 1'b1;
                tick();
                conv_comp = 1'b0;
                chk($sformatf("drain%0d_en", w), 64'(enable), 64'd0);
                tick();
            end
        end
        chk("conv_fm_count", 64'(fm_q.size()), 64'd5);
        for (int i = 0; i < fm_q.size() && i < 5; i++)
            chk($sformatf("conv_fm_addr%0d", i), 64'(fm_q[i]), 64'(i));
    endtask

    task automatic fc_job(input int fcdone_at);
        int nrd;
        wt_q.delete();
        layer_cfg = 1'b1;
        num_rows  = 8'd4;
        bias_cfg  = 16'hBEEF;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        layer_cfg = 1'b0;
        chk("fc_busy_c1", 64'(busy), 64'd1);
        repeat (7) tick();
        chk("fc_data_r3", 64'(data_row3), 64'(row_val(3)));
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("fc%0d_en", l), 64'(enable), 64'd1);
            chk($sformatf("fc%0d_layer", l), 64'(layer), 64'd1);
            chk($sformatf("fc%0d_wcol", l), 64'(fc_wcol), 64'(l));
            chk($sformatf("fc%0d_w1", l), 64'(weight_row1), 64'(wt_mem[3 * l]));
            chk($sformatf("fc%0d_w3", l), 64'(weight_row3), 64'(wt_mem[3 * l + 2]));
            fc_line_done = 1'b1;
            fc_done      = (l == fcdone_at);
            tick();
            fc_line_done = 1'b0;
            fc_done      = 1'b0;
            if (l == 3 || l == fcdone_at) begin
                chk("fc_done", 64'(done), 64'd1);
                chk("fc_done_en", 64'(enable), 64'd0);
                chk("fc_done_busy", 64'(busy), 64'd0);
                tick();
                chk("fc_done_pulse", 64'(done), 64'd0);
                break;
            end
            chk($sformatf("fc%0d_gap_wcol", l), 64'(fc_wcol), 64'(l + 1));
            chk($sformatf("fc%0d_gap_addr", l), 64'(wt_rd_addr), 64'(3 * (l + 1)));
            chk($sformatf("fc%0d_gap_rd", l), 64'(wt_rd_en), 64'd1);
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("fc%0d_gap%0d_en", l, g), 64'(enable), 64'd0);
                tick();
            end
        end
        nrd = (fcdone_at < 4) ? 3 * (fcdone_at + 1) : 12;
        chk("fc_wt_count", 64'(wt_q.size()), 64'(nrd));
        for (int i = 0; i < wt_q.size() && i < 12; i++)
            chk($sformatf("fc_wt_addr%0d", i), 64'(wt_q[i]), 64'(i));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            fm_mem[i] = row_val(i + 1);
            wt_mem[i] = 32'hA500_0000 + 32'(i);
        end
        rst = 1'b1; start = 1'b0; layer_cfg = 1'b0; num_rows = '0; bias_cfg = '0;
        conv_comp = 1'b0; fc_line_done = 1'b0; fc_done = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_en", 64'(enable), 64'd0);
        chk("rst_fc_wcol", 64'(fc_wcol), 64'd0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a running conv job.
        layer_cfg = 1'b0; num_rows = 8'd5; bias_cfg = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mid_en", 64'(enable), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_en", 64'(enable), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_r1", 64'(data_row1), 64'd0);
        chk("mid_rst_w1", 64'(weight_row1), 64'd0);
        chk("mid_rst_bias", 64'(bias), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        conv_job(1'b0);
        conv_job(1'b1);
        fc_job(99);
        fc_job(1);

        // Degenerate configurations.
        fm_q.delete(); wt_q.delete();
        layer_cfg = 1'b0; num_rows = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("h2_done", 64'(done), 64'd1);
        chk("h2_err", 64'(err), 64'd1);
        chk("h2_busy", 64'(busy), 64'd0);
        tick();
        chk("h2_done_pulse", 64'(done), 64'd0);
        chk("h2_err_pulse", 64'(err), 64'd0);
        layer_cfg = 1'b1; num_rows = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("c0_done", 64'(done), 64'd1);
        chk("c0_err", 64'(err), 64'd0);
        tick();
        chk("degen_reads", 64'(fm_q.size() + wt_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
